// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline stage registers:
// default widths, control-bundle field offsets and the stage bundle type.
package pipe_pkg;

    localparam int CTRL_W_DEFAULT = 10;
    localparam int DATA_W_DEFAULT = 64;

    // Bit offsets of the fields packed into the control bundle.
    localparam int RR_A3_SEL    = 0;
    localparam int RR_WR_EN     = 1;
    localparam int EXE_ALU_SRC2 = 2;
    localparam int EXE_ALU_OPER = 3;
    localparam int REG_D3_SEL   = 7;
    localparam int MEM_WR_EN    = 9;

    localparam logic [CTRL_W_DEFAULT-1:0] CTRL_NOP = '0;

    typedef struct packed {
        logic [CTRL_W_DEFAULT-1:0] ctrl;
        logic [DATA_W_DEFAULT-1:0] data;
    } stage_bundle_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Second holding entry for pipe_stage_reg; catches the bundle accepted
// while the main entry is stalled and hands it back on the next emit.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic              i_unload,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end else if (i_unload) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage register with flush and a saturating
// stall counter. Define PIPE_STAGE_SKID_EN to add a skid entry (registered in_ready).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CTRL_W = CTRL_W_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_stallCnt;

    logic              w_advance;
    logic              w_srcValid;
    logic [CTRL_W-1:0] w_srcCtrl;
    logic [DATA_W-1:0] w_srcData;

    // Main entry may take a new bundle when it is empty or being emitted.
    assign w_advance = !r_valid || out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              w_skidValid;
    logic              w_skidLoad;
    logic [CTRL_W-1:0] w_skidCtrl;
    logic [DATA_W-1:0] w_skidData;

    assign w_skidLoad = in_valid && !w_skidValid && r_valid && !out_ready;

    pipe_skid_buf #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (flush),
        .i_load   (w_skidLoad),
        .i_unload (r_valid && out_ready),
        .i_ctrl   (in_ctrl),
        .i_data   (in_data),
        .o_valid  (w_skidValid),
        .o_ctrl   (w_skidCtrl),
        .o_data   (w_skidData)
    );

    assign in_ready = !w_skidValid;

    // The skid entry is older than anything upstream, so it refills main first.
    always_comb begin
        w_srcValid = in_valid;
        w_srcCtrl  = in_ctrl;
        w_srcData  = in_data;
        if (w_skidValid) begin
            w_srcValid = 1'b1;
            w_srcCtrl  = w_skidCtrl;
            w_srcData  = w_skidData;
        end
    end
`else
    assign in_ready   = w_advance;
    assign w_srcValid = in_valid;
    assign w_srcCtrl  = in_ctrl;
    assign w_srcData  = in_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (w_advance) begin
            r_valid <= w_srcValid;
            if (w_srcValid) begin
                r_ctrl <= w_srcCtrl;
                r_data <= w_srcData;
            end else begin
                r_ctrl <= '0;
            end
        end
    end

    // Counts stalled cycles independent of flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if (r_valid && !out_ready && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid = r_valid;
    assign out_ctrl  = r_ctrl;
    assign out_data  = r_data;
    assign stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int DATA_W  = 64;
    localparam int CTRL_W  = 10;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef logic [CTRL_W+DATA_W-1:0] bundle_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic [CNT_W-1:0]  stall_cnt;

    int      compared   = 0;
    int      mismatched = 0;
    bit      checkEn    = 1'b0;
    int      accCount   = 0;
    bundle_t modelQ[$];
    int      modelCnt   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    function automatic bit modelInReady();
`ifdef PIPE_STAGE_SKID_EN
        return modelQ.size() < DEPTH;
`else
        return (modelQ.size() == 0) || out_ready;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic inv, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                                 input logic ordy, input logic fl, input logic r);
        in_valid  = inv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    // Reference model: an ordered list of held bundles of bounded depth.
    always @(posedge clk) begin : model
        bit acc;
        bit emt;
        acc = in_valid && modelInReady();
        emt = (modelQ.size() > 0) && out_ready;
        if (rst) begin
            modelQ.delete();
            modelCnt = 0;
        end else begin
            if ((modelQ.size() > 0) && !out_ready && (modelCnt < CNT_MAX)) modelCnt++;
            if (flush) begin
                modelQ.delete();
            end else begin
                if (emt) void'(modelQ.pop_front());
                if (acc) modelQ.push_back({in_ctrl, in_data});
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) accCount++;
    end

    always @(negedge clk) begin : compare
        bundle_t head;
        bit      expValid;
        if (checkEn) begin
            expValid = modelQ.size() > 0;
            head     = expValid ? modelQ[0] : '0;
            checkOutput("out_valid", 64'(out_valid), 64'(expValid));
            checkOutput("out_ctrl", 64'(out_ctrl), expValid ? 64'(head[DATA_W +: CTRL_W]) : 64'h0);
            if (expValid) checkOutput("out_data", out_data, head[DATA_W-1:0]);
            checkOutput("in_ready", 64'(in_ready), 64'(modelInReady()));
            checkOutput("stall_cnt", 64'(stall_cnt), 64'(modelCnt));
        end
    end

    initial begin
        int accBase;
        logic inv, ordy, fl, r;
        rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        checkEn = 1'b1;

        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        checkOutput("rst_valid", 64'(out_valid), 64'h0);
        checkOutput("rst_ctrl", 64'(out_ctrl), 64'h0);
        checkOutput("rst_data", out_data, 64'h0);
        checkOutput("rst_stall", 64'(stall_cnt), 64'h0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'h1);

        applyStimulus(1'b1, 10'h155, 64'hA5, 1'b1, 1'b0, 1'b0);
        checkOutput("first_valid", 64'(out_valid), 64'h1);
        checkOutput("first_ctrl", 64'(out_ctrl), 64'h155);
        checkOutput("first_data", out_data, 64'hA5);
        checkOutput("first_in_ready", 64'(in_ready), 64'h1);

        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, CTRL_W'(i), DATA_W'(i), 1'b1, 1'b0, 1'b0);
            checkOutput("stream_valid", 64'(out_valid), 64'h1);
            checkOutput("stream_data", out_data, 64'(i));
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("drain_valid", 64'(out_valid), 64'h0);
        checkOutput("drain_ctrl", 64'(out_ctrl), 64'h0);

        applyStimulus(1'b1, 10'h2, 64'h100, 1'b1, 1'b0, 1'b0);
        accBase = accCount;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 10'h3, 64'h200, 1'b0, 1'b0, 1'b0);
            checkOutput("hold_data", out_data, 64'h100);
            checkOutput("hold_ctrl", 64'(out_ctrl), 64'h2);
        end
        checkOutput("bp_stall", 64'(stall_cnt), 64'h5);
        checkOutput("bp_model_stall", 64'(modelCnt), 64'h5);
        checkOutput("bp_in_ready", 64'(in_ready), 64'h0);
        checkOutput("bp_extra_accepts", 64'(accCount - accBase), 64'(DEPTH - 1));
        repeat (3) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b1, 10'h4, 64'h300, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'h3FF, 64'hDEAD, 1'b0, 1'b1, 1'b0);
        checkOutput("flush_valid", 64'(out_valid), 64'h0);
        checkOutput("flush_ctrl", 64'(out_ctrl), 64'h0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_dropped", 64'(out_valid), 64'h0);
        checkOutput("flush_keeps_stall", 64'(stall_cnt), 64'h6);

        applyStimulus(1'b1, 10'h5, 64'h500, 1'b0, 1'b0, 1'b0);
        repeat (20) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("sat_stall", 64'(stall_cnt), 64'hF);
        checkOutput("sat_model", 64'(modelCnt), 64'hF);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("sat_hold", 64'(stall_cnt), 64'hF);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        checkOutput("sat_rst", 64'(stall_cnt), 64'h0);

        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'h6, 64'h600, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'h3FF, 64'hBEEF, 1'b1, 1'b1, 1'b1);
        checkOutput("rstfl_valid", 64'(out_valid), 64'h0);
        checkOutput("rstfl_ctrl", 64'(out_ctrl), 64'h0);
        checkOutput("rstfl_data", out_data, 64'h0);
        checkOutput("rstfl_stall", 64'(stall_cnt), 64'h0);
        applyStimulus(1'b1, 10'h0AB, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, 1'b0);
        checkOutput("post_rst_valid", 64'(out_valid), 64'h1);
        checkOutput("post_rst_ctrl", 64'(out_ctrl), 64'h0AB);
        checkOutput("post_rst_data", out_data, 64'h1234_5678_9ABC_DEF0);

        for (int n = 0; n < 3000; n++) begin
            inv  = $urandom_range(0, 99) < 70;
            ordy = $urandom_range(0, 99) < 60;
            fl   = $urandom_range(0, 99) < 4;
            r    = $urandom_range(0, 199) == 0;
            applyStimulus(inv, CTRL_W'($urandom), {$urandom, $urandom}, ordy, fl, r);
        end

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
